// File: rtl/sh4_fpu_wb_if.sv
// Signal bundle between the FPU/load/issue side and the FP writeback block.
// The writeback block uses the slave view.
interface sh4_fpu_wb_if;
  logic        fpu_valid;
  logic        fpu_wen;
  logic [3:0]  fpu_wdst;
  logic        fpu_wbank;
  logic [31:0] fpu_wdata;
  logic        fpu_t_wen;
  logic        fpu_t;
  logic        fpu_fpul_wen;
  logic [31:0] fpu_fpul;
  logic        ld_valid;
  logic [3:0]  ld_wdst;
  logic        ld_wbank;
  logic [31:0] ld_wdata;
  logic        iss_valid;
  logic [3:0]  iss_wdst;
  logic        iss_wbank;
  logic [3:0]  chk_dst;
  logic        chk_bank;
  logic        chk_busy;
  logic        fifo_afull;
  logic        rf_wen;
  logic        rf_wbank;
  logic [3:0]  rf_wdst;
  logic [31:0] rf_wdata;
  logic        t_wen;
  logic        t;
  logic        fpul_wen;
  logic [31:0] fpul;
  logic        ovf_err;

  modport master (
    output fpu_valid, fpu_wen, fpu_wdst, fpu_wbank, fpu_wdata,
           fpu_t_wen, fpu_t, fpu_fpul_wen, fpu_fpul,
           ld_valid, ld_wdst, ld_wbank, ld_wdata,
           iss_valid, iss_wdst, iss_wbank, chk_dst, chk_bank,
    input  chk_busy, fifo_afull, rf_wen, rf_wbank, rf_wdst, rf_wdata,
           t_wen, t, fpul_wen, fpul, ovf_err
  );

  modport slave (
    input  fpu_valid, fpu_wen, fpu_wdst, fpu_wbank, fpu_wdata,
           fpu_t_wen, fpu_t, fpu_fpul_wen, fpu_fpul,
           ld_valid, ld_wdst, ld_wbank, ld_wdata,
           iss_valid, iss_wdst, iss_wbank, chk_dst, chk_bank,
    output chk_busy, fifo_afull, rf_wen, rf_wbank, rf_wdst, rf_wdata,
           t_wen, t, fpul_wen, fpul, ovf_err
  );
endinterface

// File: rtl/sh4_fpu_wb.sv
// FP writeback merge: load path and queued FPU results share one register-file
// write port; also forwards T/FPUL updates and tracks pending FP destinations.
module sh4_fpu_wb #(
  parameter int FIFO_DEPTH = 4,
  parameter int AFULL_LVL  = 2
) (
  input  logic         clk,
  input  logic         rst,
  sh4_fpu_wb_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic        bank;
    logic [3:0]  dst;
    logic [31:0] data;
  } wr_ent_t;

  wr_ent_t            mem_q [FIFO_DEPTH];
  wr_ent_t            mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               rf_wen_q, rf_wen_d;
  wr_ent_t            rf_q, rf_d;
  logic               t_wen_q, t_wen_d;
  logic               t_q, t_d;
  logic               fpul_wen_q, fpul_wen_d;
  logic [31:0]        fpul_q, fpul_d;

  logic               push, pop, bypass, enq, drop, empty, full, clr_en;
  wr_ent_t            in_ent;

  always_comb begin
    in_ent = '{bank: bus.fpu_wbank, dst: bus.fpu_wdst, data: bus.fpu_wdata};
    push   = bus.fpu_valid & bus.fpu_wen;
    empty  = (cnt_q == '0);
    full   = (cnt_q == CNT_W'(FIFO_DEPTH));
    pop    = ~bus.ld_valid & ~empty;
    bypass = ~bus.ld_valid & empty & push;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    enq    = push & ~bypass & (~full | pop);
    drop   = push & ~bypass & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rf_wen_d = 1'b0;
    rf_d     = rf_q;
    clr_en   = 1'b0;

    if (bus.ld_valid) begin
      rf_wen_d = 1'b1;
      rf_d     = '{bank: bus.ld_wbank, dst: bus.ld_wdst, data: bus.ld_wdata};
    end else if (pop) begin
      rf_wen_d = 1'b1;
      rf_d     = mem_q[rd_ptr_q];
      clr_en   = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else if (bypass) begin
      rf_wen_d = 1'b1;
      rf_d     = in_ent;
      clr_en   = 1'b1;
    end

    if (enq) begin
      mem_d[wr_ptr_q] = in_ent;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    case ({enq, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Clear first so a same-cycle issue to the retiring register keeps it busy.
    busy_d = busy_q;
    if (clr_en)
      busy_d[{rf_d.bank, rf_d.dst}] = 1'b0;
    if (bus.iss_valid)
      busy_d[{bus.iss_wbank, bus.iss_wdst}] = 1'b1;

    ovf_d = ovf_q | drop;

    t_wen_d    = bus.fpu_valid & bus.fpu_t_wen;
    t_d        = t_wen_d ? bus.fpu_t : t_q;
    fpul_wen_d = bus.fpu_valid & bus.fpu_fpul_wen;
    fpul_d     = fpul_wen_d ? bus.fpu_fpul : fpul_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= '0;
      ovf_q      <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_q       <= '0;
      t_wen_q    <= 1'b0;
      t_q        <= 1'b0;
      fpul_wen_q <= 1'b0;
      fpul_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      rf_wen_q   <= rf_wen_d;
      rf_q       <= rf_d;
      t_wen_q    <= t_wen_d;
      t_q        <= t_d;
      fpul_wen_q <= fpul_wen_d;
      fpul_q     <= fpul_d;
    end
  end

  // Queue storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.chk_busy   = busy_q[{bus.chk_bank, bus.chk_dst}];
  assign bus.fifo_afull = (FIFO_DEPTH - int'(cnt_q)) <= AFULL_LVL;
  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_wbank   = rf_q.bank;
  assign bus.rf_wdst    = rf_q.dst;
  assign bus.rf_wdata   = rf_q.data;
  assign bus.t_wen      = t_wen_q;
  assign bus.t          = t_q;
  assign bus.fpul_wen   = fpul_wen_q;
  assign bus.fpul       = fpul_q;
  assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_sh4_fpu_wb.sv
// Bench for sh4_fpu_wb: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_sh4_fpu_wb;
  localparam int DEPTH = 4;
  localparam int AFULL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sh4_fpu_wb_if bus ();
  sh4_fpu_wb #(.FIFO_DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        bank;
    logic [3:0]  dst;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic v, wen, bank; logic [3:0] dst; logic [31:0] data;
    logic twen, t, fwen; logic [31:0] fpul;
    logic x_rwen, x_rbank; logic [3:0] x_rdst; logic [31:0] x_rdata;
    logic x_twen, x_t, x_fwen; logic [31:0] x_fpul;
  } vec_t;

  ent_t        mq[$];
  logic [31:0] mbusy;
  logic        movf;
  logic        e_rf_wen, e_rf_wbank, e_t_wen, e_t, e_fpul_wen;
  logic [3:0]  e_rf_wdst;
  logic [31:0] e_rf_wdata, e_fpul;
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        tbl[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.fpu_valid = 1'b0; bus.fpu_wen = 1'b0; bus.fpu_wdst = '0; bus.fpu_wbank = 1'b0;
    bus.fpu_wdata = '0; bus.fpu_t_wen = 1'b0; bus.fpu_t = 1'b0; bus.fpu_fpul_wen = 1'b0;
    bus.fpu_fpul = '0; bus.ld_valid = 1'b0; bus.ld_wdst = '0; bus.ld_wbank = 1'b0;
    bus.ld_wdata = '0; bus.iss_valid = 1'b0; bus.iss_wdst = '0; bus.iss_wbank = 1'b0;
    bus.chk_dst = '0; bus.chk_bank = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy = '0; movf = 1'b0;
    e_rf_wen = 1'b0; e_rf_wbank = 1'b0; e_rf_wdst = '0; e_rf_wdata = '0;
    e_t_wen = 1'b0; e_t = 1'b0; e_fpul_wen = 1'b0; e_fpul = '0;
  endtask

  // One clock of behaviour: who owns the write port, what the queue holds,
  // which destinations remain pending.
  task automatic model_step();
    ent_t inc, h;
    logic push, taken;
    inc.bank = bus.fpu_wbank; inc.dst = bus.fpu_wdst; inc.data = bus.fpu_wdata;
    push  = bus.fpu_valid && bus.fpu_wen;
    taken = 1'b0;
    e_rf_wen = 1'b0;
    if (bus.ld_valid) begin
      e_rf_wen = 1'b1; e_rf_wbank = bus.ld_wbank; e_rf_wdst = bus.ld_wdst; e_rf_wdata = bus.ld_wdata;
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      e_rf_wen = 1'b1; e_rf_wbank = h.bank; e_rf_wdst = h.dst; e_rf_wdata = h.data;
      mbusy[{h.bank, h.dst}] = 1'b0;
    end else if (push) begin
      e_rf_wen = 1'b1; e_rf_wbank = inc.bank; e_rf_wdst = inc.dst; e_rf_wdata = inc.data;
      mbusy[{inc.bank, inc.dst}] = 1'b0;
      taken = 1'b1;
    end
    if (push && !taken) begin
      if (mq.size() < DEPTH) mq.push_back(inc);
      else movf = 1'b1;
    end
    if (bus.iss_valid) mbusy[{bus.iss_wbank, bus.iss_wdst}] = 1'b1;
    e_t_wen    = bus.fpu_valid && bus.fpu_t_wen;
    if (e_t_wen) e_t = bus.fpu_t;
    e_fpul_wen = bus.fpu_valid && bus.fpu_fpul_wen;
    if (e_fpul_wen) e_fpul = bus.fpu_fpul;
  endtask

  task automatic post_check();
    check("rf_wen",   bus.rf_wen,   e_rf_wen);
    check("rf_wbank", bus.rf_wbank, e_rf_wbank);
    check("rf_wdst",  bus.rf_wdst,  e_rf_wdst);
    check("rf_wdata", bus.rf_wdata, e_rf_wdata);
    check("t_wen",    bus.t_wen,    e_t_wen);
    check("t",        bus.t,        e_t);
    check("fpul_wen", bus.fpul_wen, e_fpul_wen);
    check("fpul",     bus.fpul,     e_fpul);
    check("ovf_err",  bus.ovf_err,  movf);
  endtask

  task automatic pre_check();
    check("chk_busy",   bus.chk_busy,   mbusy[{bus.chk_bank, bus.chk_dst}]);
    check("fifo_afull", bus.fifo_afull, (DEPTH - mq.size()) <= AFULL);
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    #1;
    pre_check();
    model_step();
    @(posedge clk);
    #1;
    post_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    post_check();
  endtask

  task automatic push_fpu(input logic bank, input logic [3:0] dst, input logic [31:0] data);
    bus.fpu_valid = 1'b1; bus.fpu_wen = 1'b1;
    bus.fpu_wbank = bank; bus.fpu_wdst = dst; bus.fpu_wdata = data;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_wr;
    tbl[0] = '{1'b1,1'b1,1'b1,4'd5,32'h3F800000, 1'b0,1'b0,1'b0,32'h0,
               1'b1,1'b1,4'd5,32'h3F800000, 1'b0,1'b0,1'b0,32'h0};
    tbl[1] = '{1'b1,1'b0,1'b0,4'd0,32'h0, 1'b1,1'b1,1'b0,32'h0,
               1'b0,1'b1,4'd5,32'h3F800000, 1'b1,1'b1,1'b0,32'h0};
    tbl[2] = '{1'b0,1'b0,1'b0,4'd0,32'h0, 1'b0,1'b0,1'b0,32'h0,
               1'b0,1'b1,4'd5,32'h3F800000, 1'b0,1'b1,1'b0,32'h0};
    tbl[3] = '{1'b1,1'b0,1'b0,4'd0,32'h0, 1'b0,1'b0,1'b1,32'hDEADBEEF,
               1'b0,1'b1,4'd5,32'h3F800000, 1'b0,1'b1,1'b1,32'hDEADBEEF};
    tbl[4] = '{1'b1,1'b1,1'b0,4'd15,32'h00000001, 1'b1,1'b0,1'b1,32'h12345678,
               1'b1,1'b0,4'd15,32'h00000001, 1'b1,1'b0,1'b1,32'h12345678};
    tbl[5] = '{1'b0,1'b1,1'b1,4'd3,32'h00000055, 1'b1,1'b1,1'b1,32'hFFFFFFFF,
               1'b0,1'b0,4'd15,32'h00000001, 1'b0,1'b0,1'b0,32'h12345678};

    idle();
    rst = 1'b1;
    model_reset();
    #12;
    pre_check();
    post_check();
    rst = 1'b0;

    // Vector table; busy[21] is set first so the bypass write must clear it.
    bus.iss_valid = 1'b1; bus.iss_wbank = 1'b1; bus.iss_wdst = 4'd5;
    bus.chk_bank = 1'b1; bus.chk_dst = 4'd5;
    cycle();
    check("busy21_set", bus.chk_busy, 1);
    bus.iss_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.fpu_valid = tbl[i].v; bus.fpu_wen = tbl[i].wen; bus.fpu_wbank = tbl[i].bank;
      bus.fpu_wdst = tbl[i].dst; bus.fpu_wdata = tbl[i].data; bus.fpu_t_wen = tbl[i].twen;
      bus.fpu_t = tbl[i].t; bus.fpu_fpul_wen = tbl[i].fwen; bus.fpu_fpul = tbl[i].fpul;
      cycle();
      check("vec_rf_wen",   bus.rf_wen,   tbl[i].x_rwen);
      check("vec_rf_wbank", bus.rf_wbank, tbl[i].x_rbank);
      check("vec_rf_wdst",  bus.rf_wdst,  tbl[i].x_rdst);
      check("vec_rf_wdata", bus.rf_wdata, tbl[i].x_rdata);
      check("vec_t_wen",    bus.t_wen,    tbl[i].x_twen);
      check("vec_t",        bus.t,        tbl[i].x_t);
      check("vec_fpul_wen", bus.fpul_wen, tbl[i].x_fwen);
      check("vec_fpul",     bus.fpul,     tbl[i].x_fpul);
      if (i == 0) check("bypass_busy_clr", bus.chk_busy, 0);
    end

    // Scoreboard: set, set-wins-over-clear, clear, load does not clear.
    idle();
    bus.chk_bank = 1'b0; bus.chk_dst = 4'd2;
    bus.iss_valid = 1'b1; bus.iss_wbank = 1'b0; bus.iss_wdst = 4'd2;
    cycle();
    check("sb_set", bus.chk_busy, 1);
    push_fpu(1'b0, 4'd2, 32'h00000011);
    cycle();
    check("sb_set_wins", bus.chk_busy, 1);
    check("sb_write", bus.rf_wen, 1);
    bus.iss_valid = 1'b0;
    push_fpu(1'b0, 4'd2, 32'h00000022);
    cycle();
    check("sb_clear", bus.chk_busy, 0);
    bus.fpu_valid = 1'b0; bus.iss_valid = 1'b1;
    cycle();
    bus.iss_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_wbank = 1'b0; bus.ld_wdst = 4'd2; bus.ld_wdata = 32'h0000AAAA;
    cycle();
    check("sb_load_keeps", bus.chk_busy, 1);

    // Load priority: 4 loads win the port while 3 FPU results queue up.
    do_reset();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_wbank = 1'b0; bus.ld_wdst = 4'(i); bus.ld_wdata = 32'hA0000000 + i;
      if (i < 3) push_fpu(1'b1, 4'(8 + i), 32'hF0000000 + i);
      else bus.fpu_valid = 1'b0;
      cycle();
      check("ld_order", bus.rf_wdata, 32'hA0000000 + i);
      if (i == 1) check("afull_at_2", bus.fifo_afull, 1);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("fpu_after_ld_wen", bus.rf_wen, 1);
      check("fpu_after_ld_data", bus.rf_wdata, 32'hF0000000 + i);
    end
    cycle();
    check("ld_seq_idle", bus.rf_wen, 0);

    // Overflow: fifth result is dropped while loads hold the port.
    do_reset();
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = 1'b1; bus.ld_wdata = 32'hB0000000 + i;
      push_fpu(1'b0, 4'(i), 32'hC0000000 + i);
      cycle();
      check("ovf_err_seq", bus.ovf_err, (i == 4) ? 32'd1 : 32'd0);
    end
    idle();
    n_wr = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bus.rf_wen) begin
        check("drain_data", bus.rf_wdata, 32'hC0000000 + n_wr);
        n_wr++;
      end
    end
    check("drain_count", n_wr, 4);
    check("ovf_sticky", bus.ovf_err, 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.fpu_valid    = ($urandom_range(0, 2) != 0);
      bus.fpu_wen      = ($urandom_range(0, 3) != 0);
      bus.fpu_wbank    = 1'($urandom());
      bus.fpu_wdst     = 4'($urandom());
      bus.fpu_wdata    = $urandom();
      bus.fpu_t_wen    = 1'($urandom());
      bus.fpu_t        = 1'($urandom());
      bus.fpu_fpul_wen = 1'($urandom());
      bus.fpu_fpul     = $urandom();
      bus.ld_valid     = ($urandom_range(0, 2) == 0);
      bus.ld_wbank     = 1'($urandom());
      bus.ld_wdst      = 4'($urandom());
      bus.ld_wdata     = $urandom();
      bus.iss_valid    = 1'($urandom());
      bus.iss_wbank    = 1'($urandom());
      bus.iss_wdst     = 4'($urandom());
      bus.chk_bank     = 1'($urandom());
      bus.chk_dst      = 4'($urandom());
      cycle();
    end

    // Asynchronous reset with three results queued.
    do_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1; bus.ld_wdata = 32'hD0000000 + i;
      push_fpu(1'b1, 4'(i), 32'hE0000000 + i);
      bus.fpu_t_wen = 1'b1; bus.fpu_t = 1'b1;
      bus.fpu_fpul_wen = 1'b1; bus.fpu_fpul = 32'h0F0F0F0F;
      bus.iss_valid = 1'b1; bus.iss_wbank = 1'b1; bus.iss_wdst = 4'(i);
      cycle();
    end
    idle();
    #3;
    rst = 1'b1;
    #1;
    check("arst_rf_wen",   bus.rf_wen,   0);
    check("arst_rf_wdata", bus.rf_wdata, 0);
    check("arst_t",        bus.t,        0);
    check("arst_fpul",     bus.fpul,     0);
    check("arst_afull",    bus.fifo_afull, 0);
    model_reset();
    post_check();
    #2;
    rst = 1'b0;
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      bus.chk_bank = 1'b1; bus.chk_dst = 4'(i);
      cycle();
      if (bus.rf_wen) n_wr++;
    end
    check("arst_no_writes", n_wr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
